// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the regfile_bank register file: the init-sweep state
// type, the default geometry and the architectural zero-register index.
// Optional feature macro used by the block: REGFILE_BYPASS_EN.
// -----------------------------------------------------------------------------
package regfile_pkg;

   // Sweep FSM: CLEAR initialises the array, RUN is normal operation.
   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_e;

   localparam int DATA_W_DEF = 64;
   localparam int ADDR_W_DEF = 5;
   localparam int XZR_IDX    = 31;

endpackage : regfile_pkg

// File: rtl/regfile_read_port.sv
// -----------------------------------------------------------------------------
// regfile_read_port
// One combinational read port of regfile_bank: selects the addressed entry,
// forces zero for the zero register and while the init sweep is running, and
// (with REGFILE_BYPASS_EN defined) forwards same-cycle write data.
// Ports:
//   ready_i    - sweep complete; when low the port returns 0
//   rd_addr_i  - read address
//   mem_i      - register array contents
//   wr_req_i   - a write is being performed this cycle (REGFILE_BYPASS_EN only)
//   wr_addr_i  - write address (REGFILE_BYPASS_EN only)
//   wr_data_i  - write data (REGFILE_BYPASS_EN only)
//   rd_data_o  - read data
// -----------------------------------------------------------------------------
module regfile_read_port
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DEPTH    = 1 << ADDR_W,
   parameter int ZERO_REG = XZR_IDX
) (
   input  logic              ready_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   input  logic [DATA_W-1:0] mem_i [DEPTH],
`ifdef REGFILE_BYPASS_EN
   input  logic              wr_req_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
`endif
   output logic [DATA_W-1:0] rd_data_o
);

   // An out-of-range ZERO_REG disables the zero register entirely.
   localparam bit                ZERO_EN   = (ZERO_REG < DEPTH);
   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

   logic is_zero_s;

   // Decode whether this port addresses the hardwired zero register.
   always_comb begin
      is_zero_s = ZERO_EN && (rd_addr_i == ZERO_ADDR);
   end

   // Read mux: ready gating and zero mask take priority over any data source.
   always_comb begin
      rd_data_o = {DATA_W{1'b0}};
      if (!ready_i) begin
         rd_data_o = {DATA_W{1'b0}};
      end else if (is_zero_s) begin
         rd_data_o = {DATA_W{1'b0}};
`ifdef REGFILE_BYPASS_EN
      // wr_req_i already excludes the zero register, so no extra check here.
      end else if (wr_req_i && (wr_addr_i == rd_addr_i)) begin
         rd_data_o = wr_data_i;
`endif
      end else begin
         rd_data_o = mem_i[rd_addr_i];
      end
   end

endmodule : regfile_read_port

// File: rtl/regfile_bank.sv
// -----------------------------------------------------------------------------
// regfile_bank
// General-purpose register file: two combinational read ports, one clocked
// write port, a hardwired zero register and a post-reset clear sweep that
// initialises every entry before ready rises.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-to-read
// forwarding); undefined, reads show the pre-edge array value.
// Ports:
//   CLOCK        - sole clock, rising edge
//   RESET_N      - synchronous active-low reset
//   readAddress1 - read port 1 address;  regData1 - read port 1 data
//   readAddress2 - read port 2 address;  regData2 - read port 2 data
//   writeAddress - write address; writeData - write data; regWrite - enable
//   ready        - sweep complete, writes accepted
// -----------------------------------------------------------------------------
module regfile_bank
   import regfile_pkg::*;
#(
   parameter int DATA_W        = DATA_W_DEF,
   parameter int ADDR_W        = ADDR_W_DEF,
   parameter int ZERO_REG      = XZR_IDX,
   parameter int CLEAR_PER_CYC = 1
) (
   input  logic              CLOCK,
   input  logic              RESET_N,
   input  logic [ADDR_W-1:0] readAddress1,
   input  logic [ADDR_W-1:0] readAddress2,
   input  logic [ADDR_W-1:0] writeAddress,
   input  logic [DATA_W-1:0] writeData,
   input  logic              regWrite,
   output logic [DATA_W-1:0] regData1,
   output logic [DATA_W-1:0] regData2,
   output logic              ready
);

   localparam int                DEPTH     = 1 << ADDR_W;
   localparam bit                ZERO_EN   = (ZERO_REG < DEPTH);
   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);
   // Step wraps to 0 when one cycle clears everything; the last-chunk test
   // still fires on the first sweep edge in that case.
   localparam logic [ADDR_W-1:0] CLR_STEP  = ADDR_W'(CLEAR_PER_CYC);
   localparam logic [ADDR_W-1:0] CLR_LAST  = ADDR_W'(DEPTH - CLEAR_PER_CYC);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              ready_q, ready_d;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic              wr_req_s;

   // Qualified write request: only in RUN and never to the zero register.
   always_comb begin
      wr_req_s = (state_q == ST_RUN) && regWrite &&
                 !(ZERO_EN && (writeAddress == ZERO_ADDR));
   end

   // Sweep FSM next-state logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ready_d = ready_q;
      case (state_q)
         ST_CLEAR: begin
            cnt_d = cnt_q + CLR_STEP;
            if (cnt_q == CLR_LAST) begin
               state_d = ST_RUN;
               ready_d = 1'b1;
            end else begin
               state_d = ST_CLEAR;
               ready_d = 1'b0;
            end
         end
         ST_RUN: begin
            state_d = ST_RUN;
            ready_d = 1'b1;
         end
         default: begin
            state_d = ST_CLEAR;
            cnt_d   = {ADDR_W{1'b0}};
            ready_d = 1'b0;
         end
      endcase
   end

   // Sweep FSM state register with synchronous active-low reset.
   always_ff @(posedge CLOCK) begin
      if (!RESET_N) begin
         state_q <= ST_CLEAR;
         cnt_q   <= {ADDR_W{1'b0}};
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
      end
   end

   // Register array: sweep clears a chunk per edge, otherwise the write port.
   // Contents are deliberately not reset; the sweep provides initialisation.
   always_ff @(posedge CLOCK) begin
      if (RESET_N && (state_q == ST_CLEAR)) begin
         for (int i = 0; i < CLEAR_PER_CYC; i++) begin
            mem_q[cnt_q + ADDR_W'(i)] <= {DATA_W{1'b0}};
         end
      end else if (RESET_N && wr_req_s) begin
         mem_q[writeAddress] <= writeData;
      end
   end

   assign ready = ready_q;

   regfile_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .DEPTH    (DEPTH),
      .ZERO_REG (ZERO_REG)
   ) u_rd1 (
      .ready_i   (ready_q),
      .rd_addr_i (readAddress1),
      .mem_i     (mem_q),
`ifdef REGFILE_BYPASS_EN
      .wr_req_i  (wr_req_s),
      .wr_addr_i (writeAddress),
      .wr_data_i (writeData),
`endif
      .rd_data_o (regData1)
   );

   regfile_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .DEPTH    (DEPTH),
      .ZERO_REG (ZERO_REG)
   ) u_rd2 (
      .ready_i   (ready_q),
      .rd_addr_i (readAddress2),
      .mem_i     (mem_q),
`ifdef REGFILE_BYPASS_EN
      .wr_req_i  (wr_req_s),
      .wr_addr_i (writeAddress),
      .wr_data_i (writeData),
`endif
      .rd_data_o (regData2)
   );

endmodule : regfile_bank

// File: tb/tb_regfile_bank.sv
// -----------------------------------------------------------------------------
// tb_regfile_bank
// Self-checking bench for regfile_bank at default parameters. Expected read
// data is pushed to a scoreboard queue when addresses are driven and popped
// when the combinational outputs are sampled.
// -----------------------------------------------------------------------------
module tb_regfile_bank;

   logic        CLOCK;
   logic        RESET_N;
   logic [4:0]  readAddress1;
   logic [4:0]  readAddress2;
   logic [4:0]  writeAddress;
   logic [63:0] writeData;
   logic        regWrite;
   logic [63:0] regData1;
   logic [63:0] regData2;
   logic        ready;

   regfile_bank dut (
      .CLOCK        (CLOCK),
      .RESET_N      (RESET_N),
      .readAddress1 (readAddress1),
      .readAddress2 (readAddress2),
      .writeAddress (writeAddress),
      .writeData    (writeData),
      .regWrite     (regWrite),
      .regData1     (regData1),
      .regData2     (regData2),
      .ready        (ready)
   );

   initial begin
      CLOCK = 1'b0;
      forever #5 CLOCK = ~CLOCK;
   end

   typedef struct {
      string       tag;
      int          port;
      logic [63:0] exp;
   } sb_t;

   sb_t         sb_q[$];
   logic [63:0] model_mem [32];
   bit          model_ready;
   int          n_checks;
   int          n_errors;

   task automatic check_val(input string tag, input logic [63:0] act,
                            input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Expected read value from the bench's own view of the register file.
   function automatic logic [63:0] model_read(input int addr);
      if (!model_ready || addr == 31) return 64'd0;
      return model_mem[addr];
   endfunction

   task automatic push_exp(input string tag, input int port,
                           input logic [63:0] exp);
      sb_t e;
      e.tag  = tag;
      e.port = port;
      e.exp  = exp;
      sb_q.push_back(e);
   endtask

   task automatic drain_sb();
      sb_t e;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check_val(e.tag, (e.port == 1) ? regData1 : regData2, e.exp);
      end
   endtask

   // Called at a negedge: drive both read addresses, check, advance a cycle.
   task automatic read_pair(input int a1, input int a2, input string tag);
      readAddress1 = 5'(a1);
      readAddress2 = 5'(a2);
      push_exp({tag, "_p1"}, 1, model_read(a1));
      push_exp({tag, "_p2"}, 2, model_read(a2));
      #1;
      drain_sb();
      @(negedge CLOCK);
   endtask

   // Called at a negedge: one write on the next rising edge.
   task automatic do_write(input int addr, input logic [63:0] data);
      regWrite     = 1'b1;
      writeAddress = 5'(addr);
      writeData    = data;
      @(negedge CLOCK);
      if (addr != 31) model_mem[addr] = data;
      regWrite = 1'b0;
   endtask

   // Called at a negedge with RESET_N low: release and follow the sweep.
   // ready must stay low for exactly 32 edges; optionally try a write at 10.
   task automatic run_sweep(input bit inject);
      RESET_N     = 1'b1;
      model_ready = 1'b0;
      for (int k = 0; k < 32; k++) model_mem[k] = 64'd0;
      for (int i = 0; i < 32; i++) begin
         #1;
         check_val($sformatf("sweep_ready_%0d", i), {63'd0, ready}, 64'd0);
         if (i == 0) begin
            readAddress1 = 5'd3;
            readAddress2 = 5'd1;
            #1;
            push_exp("sweep_gate_p1", 1, 64'd0);
            push_exp("sweep_gate_p2", 2, 64'd0);
            drain_sb();
         end
         if (inject && i == 10) begin
            regWrite     = 1'b1;
            writeAddress = 5'd5;
            writeData    = 64'h5555;
         end else begin
            regWrite = 1'b0;
         end
         @(negedge CLOCK);
      end
      regWrite = 1'b0;
      #1;
      check_val("sweep_done_ready", {63'd0, ready}, 64'd1);
      model_ready = 1'b1;
   endtask

   initial begin
      logic [63:0] byp_exp;
      int          ra;
      logic [63:0] rd;
      n_checks     = 0;
      n_errors     = 0;
      model_ready  = 1'b0;
      RESET_N      = 1'b0;
      regWrite     = 1'b0;
      readAddress1 = 5'd0;
      readAddress2 = 5'd0;
      writeAddress = 5'd0;
      writeData    = 64'd0;
      for (int k = 0; k < 32; k++) model_mem[k] = 64'd0;

      // Reset state.
      @(negedge CLOCK);
      @(negedge CLOCK);
      #1;
      check_val("reset_ready", {63'd0, ready}, 64'd0);
      push_exp("reset_rd_p1", 1, 64'd0);
      push_exp("reset_rd_p2", 2, 64'd0);
      drain_sb();
      @(negedge CLOCK);

      // Sweep with a write attempt to x5 during CLEAR.
      run_sweep(1'b1);

      // All entries zero after the sweep; x5 must not hold the dropped write.
      for (int i = 0; i < 32; i++) read_pair(i, 31 - i, $sformatf("init_%0d", i));

      // Back-to-back writes then read both.
      do_write(1, 64'd16);
      do_write(2, 64'd12);
      read_pair(1, 2, "x1x2");

      // Zero register ignores writes and reads 0; neighbours unchanged.
      do_write(31, 64'hDEAD);
      read_pair(31, 31, "xzr");
      read_pair(1, 2, "xzr_others");

      // Same-cycle write and read of x7.
      readAddress1 = 5'd7;
      readAddress2 = 5'd1;
      regWrite     = 1'b1;
      writeAddress = 5'd7;
      writeData    = 64'd1;
`ifdef REGFILE_BYPASS_EN
      byp_exp = 64'd1;
`else
      byp_exp = 64'd0;
`endif
      push_exp("bypass_same_cycle", 1, byp_exp);
      push_exp("bypass_other_port", 2, 64'd16);
      #1;
      drain_sb();
      @(negedge CLOCK);
      model_mem[7] = 64'd1;
      regWrite = 1'b0;
      read_pair(7, 7, "bypass_after");

      // Random write/read traffic against the model.
      for (int n = 0; n < 10; n++) begin
         ra = int'($urandom_range(0, 31));
         rd = {$urandom(), $urandom()};
         do_write(ra, rd);
         read_pair(ra, int'($urandom_range(0, 31)), $sformatf("rand_%0d", n));
      end

      // Reset in RUN reruns the sweep and clears x3.
      do_write(3, 64'h3);
      read_pair(3, 3, "x3_before_reset");
      RESET_N = 1'b0;
      @(negedge CLOCK);
      #1;
      check_val("rerun_ready_drop", {63'd0, ready}, 64'd0);
      #1;
      run_sweep(1'b0);
      @(negedge CLOCK);
      read_pair(3, 1, "x3_after_reset");
      read_pair(7, 2, "after_reset_others");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   // Hard time limit so the bench can never hang.
   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule : tb_regfile_bank
